ram8_fifo_ctrl: RTL and testbench
=================================

# ram8_fifo_ctrl

Synchronous FIFO controller that sits directly upstream of the `ram8` 8×16 single-port RAM and turns it into an 8-entry first-in/first-out buffer. It owns the write pointer, read pointer, occupancy and arbitration between push and pop. Each cycle it issues at most one `ram8` access through the RAM's single address port. Read data returns from `ram8` and is presented on the pop side.

## Interface
- `DW`, default 16: data width; must match `ram8` word width.
- `AW`, default 3: address width; depth = 2^AW = 8.

- `clk`  in  1  rising-edge clock, shared with `ram8`.
- `rst`  in  1  synchronous, active-high reset.
- `push`  in  1  write request.
- `push_data`  in  DW  data to enqueue.
- `push_ready`  out  1  push is accepted this cycle when `push & push_ready`.
- `pop`  in  1  read request.
- `pop_ready`  out  1  pop is accepted this cycle when `pop & pop_ready`.
- `pop_valid`  out  1  `pop_data` is valid; asserted the cycle after an accepted pop.
- `pop_data`  out  DW  dequeued word; equals `ram_d_out` while `pop_valid`.
- `count`  out  AW+1  occupancy, 0..8.
- `full`, `empty`  out  1  `count==8` and `count==0` respectively.
- `ovf`  out  1  sticky flag: push attempted while full; cleared only by `rst`.
- `ram_add`  out  AW  to `ram8` `add`.
- `ram_d_in`  out  DW  to `ram8` `d_in`.
- `ram_w`, `ram_r`, `ram_en`  out  1  to `ram8` `w`, `r`, `en`.
- `ram_d_out`  in  DW  from `ram8` `d_out`.

## Operation
- The `ram8` contract is fixed:
  - Write: the word is stored at the posedge where `en=1` and `w=1`.
  - Read: `d_out` is updated at the posedge where `en=1`, `r=1` and `w=0`, and holds until the next read.
- The controller never asserts `ram_w` and `ram_r` together.
- Grant logic is combinational from the current state:
  - Write-eligible: `push & ~full`.
  - Read-eligible: `pop & ~empty`.
  - If only one is eligible, grant it.
  - If both are eligible, grant per the priority bit `prio_wr`, then toggle `prio_wr`. Alternation starts with write after reset.
- `push_ready` = `~full` and not (both eligible with `prio_wr=0`).
- `pop_ready` = `~empty` and not (both eligible with `prio_wr=1`).
- On a write grant:
  - RAM outputs: `ram_en=1`, `ram_w=1`, `ram_r=0`, `ram_add=wptr`, `ram_d_in=push_data`.
  - At the edge: `wptr` increments and `count` increments.
- On a read grant:
  - RAM outputs: `ram_en=1`, `ram_r=1`, `ram_w=0`, `ram_add=rptr`.
  - At the edge: `rptr` increments, `count` decrements and `pop_valid` is set for one cycle.
- No grant: `ram_en=0`, `ram_w=0`, `ram_r=0`, `ram_add=0`, `ram_d_in=0`.
- Pointers are AW bits and wrap 7→0 naturally.
- `count` is AW+1 bits and never goes below 0 or above 8.
- `ovf` is set at any edge where `push=1` and `full=1`. That push is dropped, and no pointer or RAM change occurs.
- A pop while `empty` is ignored. No flag is raised and `pop_valid` stays 0.

## Timing
- Reset values: `wptr=0`, `rptr=0`, `count=0`, `empty=1`, `full=0`, `ovf=0`, `pop_valid=0`, `prio_wr=1`, and all `ram_*` outputs 0.
- Reset asserted mid-operation discards all contents at that edge. `pop_valid` for a read granted in the reset cycle is suppressed.
- Push-to-storage latency: 0. The word is in RAM at the edge that accepts it.
- Pop latency: 1. `pop_valid` and `pop_data` appear in the cycle after acceptance.
- Sustained pops give back-to-back `pop_valid`.
- Empty-to-pop: a word pushed at edge N can be popped with acceptance in cycle N+1 and appears on `pop_data` in cycle N+2. There is no same-cycle bypass.
- `full` and `empty` are derived from the registered `count`, so they update the cycle after the causing edge.
- With simultaneous push and pop sustained at `count` strictly between 0 and 8, throughput is 1 op/cycle, alternating write and read.

## Structure
- Shared package `ram8_pkg` holds:
  - constants `RAM8_DW=16` and `RAM8_AW=3`;
  - the op enum `ram_op_t {OP_NONE, OP_WR, OP_RD}` used by the grant logic.
- Single natural sub-module `ram8_fifo_arb`: a combinational grant plus the `prio_wr` toggle flop. Pointer, count and flag registers stay in the top.
- A top-level integration test instantiates `ram8_fifo_ctrl` together with `ram8`.

## Test plan
- Reset, then push 1..8 on 8 consecutive cycles:
  - RAM writes occur at addresses 0..7;
  - `full=1` and `count=8`;
  - a ninth push with data 9 sets `ovf=1` and changes no RAM content.
- From full, pop 8 times back-to-back: `pop_data` sequence is 1..8 with `pop_valid` high 8 cycles; then `empty=1`, `count=0`.
- Wrap-around: push 5 words, pop 5, then push 10..17 → `ram_add` runs 5,6,7,0,1,2,3,4, and pops return 10..17 in order.
- Simultaneous push and pop at `count=4` for 6 cycles: grants alternate W,R,W,R,W,R; `count` ends at 4; `ram_w` and `ram_r` are never high together.
- Pop on empty, and push+pop on empty: the pop is ignored and `pop_valid=0`; the push is accepted; the next cycle shows `count=1`.
- Reset asserted while `count=6` with a pop granted in the same cycle: next cycle `count=0`, `pop_valid=0`, `ovf=0`, and pointers are 0.

Source files
------------

// File: rtl/ram8_pkg.sv
// ram8_pkg: shared constants and types for the ram8 FIFO controller slice.
//   RAM8_DW  - ram8 word width
//   RAM8_AW  - ram8 address width (depth = 2**RAM8_AW)
//   ram_op_t - the single RAM access chosen for a cycle
package ram8_pkg;

    localparam int unsigned RAM8_DW = 16;
    localparam int unsigned RAM8_AW = 3;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_WR   = 2'd1,
        OP_RD   = 2'd2
    } ram_op_t;

endpackage

// File: rtl/ram8_fifo_ctrl_if.sv
// ram8_fifo_ctrl_if: push/pop handshake, status and ram8 port bundle.
//   push/push_data/push_ready          - enqueue handshake
//   pop/pop_ready/pop_valid/pop_data   - dequeue handshake and returned word
//   count/full/empty/ovf               - occupancy and sticky overflow status
//   ram_add/ram_d_in/ram_w/ram_r/ram_en/ram_d_out - ram8 single-port access
// Modports: slave = controller side, master = user/RAM side.
interface ram8_fifo_ctrl_if #(
    parameter int unsigned DW = ram8_pkg::RAM8_DW,
    parameter int unsigned AW = ram8_pkg::RAM8_AW
);

    logic          push;
    logic [DW-1:0] push_data;
    logic          push_ready;
    logic          pop;
    logic          pop_ready;
    logic          pop_valid;
    logic [DW-1:0] pop_data;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          ovf;
    logic [AW-1:0] ram_add;
    logic [DW-1:0] ram_d_in;
    logic          ram_w;
    logic          ram_r;
    logic          ram_en;
    logic [DW-1:0] ram_d_out;

    modport slave (
        input  push, push_data, pop, ram_d_out,
        output push_ready, pop_ready, pop_valid, pop_data,
               count, full, empty, ovf,
               ram_add, ram_d_in, ram_w, ram_r, ram_en
    );

    modport master (
        output push, push_data, pop, ram_d_out,
        input  push_ready, pop_ready, pop_valid, pop_data,
               count, full, empty, ovf,
               ram_add, ram_d_in, ram_w, ram_r, ram_en
    );

endinterface

// File: rtl/ram8_fifo_arb.sv
// ram8_fifo_arb: picks at most one RAM access per cycle between push and pop.
//   clk, rst             - clock, synchronous active-high reset
//   push_i, pop_i        - raw requests
//   full_i, empty_i      - occupancy status from the controller
//   op_o                 - granted access (combinational)
//   push_ready_o, pop_ready_o - handshake readies (combinational)
module ram8_fifo_arb
    import ram8_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    push_i,
    input  logic    pop_i,
    input  logic    full_i,
    input  logic    empty_i,
    output ram_op_t op_o,
    output logic    push_ready_o,
    output logic    pop_ready_o
);

    logic prio_wr_q;
    logic prio_wr_d;
    logic wr_elig;
    logic rd_elig;
    logic both;

    assign wr_elig = push_i & ~full_i;
    assign rd_elig = pop_i & ~empty_i;
    assign both    = wr_elig & rd_elig;

    // Contention alternates; the loser sees its ready drop for that cycle.
    always_comb begin
        op_o         = OP_NONE;
        push_ready_o = ~full_i & ~(both & ~prio_wr_q);
        pop_ready_o  = ~empty_i & ~(both & prio_wr_q);
        prio_wr_d    = prio_wr_q;
        if (both) begin
            op_o      = prio_wr_q ? OP_WR : OP_RD;
            prio_wr_d = ~prio_wr_q;
        end else if (wr_elig) begin
            op_o = OP_WR;
        end else if (rd_elig) begin
            op_o = OP_RD;
        end
    end

    // Write wins the first contention after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_wr_q <= 1'b1;
        end else begin
            prio_wr_q <= prio_wr_d;
        end
    end

endmodule

// File: rtl/ram8_fifo_ctrl.sv
// ram8_fifo_ctrl: turns the ram8 single-port RAM into an 8-deep FIFO.
//   clk, rst - clock, synchronous active-high reset
//   bus      - slave side of ram8_fifo_ctrl_if (handshakes, status, ram8 port)
// Writes land in RAM at the accepting edge; read data returns one cycle
// after the accepted pop straight from ram8 d_out.
module ram8_fifo_ctrl
    import ram8_pkg::*;
#(
    parameter int unsigned DW = RAM8_DW,
    parameter int unsigned AW = RAM8_AW
) (
    input  logic               clk,
    input  logic               rst,
    ram8_fifo_ctrl_if.slave    bus
);

    localparam int unsigned   CW    = AW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(1 << AW);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          pop_valid_q, pop_valid_d;

    logic          full_c;
    logic          empty_c;
    ram_op_t       op_c;
    logic          push_ready_c;
    logic          pop_ready_c;

    logic [AW-1:0] ram_add_c;
    logic [DW-1:0] ram_d_in_c;
    logic          ram_w_c;
    logic          ram_r_c;
    logic          ram_en_c;

    assign full_c  = (count_q == DEPTH);
    assign empty_c = (count_q == '0);

    ram8_fifo_arb u_arb (
        .clk          (clk),
        .rst          (rst),
        .push_i       (bus.push),
        .pop_i        (bus.pop),
        .full_i       (full_c),
        .empty_i      (empty_c),
        .op_o         (op_c),
        .push_ready_o (push_ready_c),
        .pop_ready_o  (pop_ready_c)
    );

    // RAM port drive for the granted access; idle cycles park everything at 0.
    always_comb begin
        ram_add_c  = '0;
        ram_d_in_c = '0;
        ram_w_c    = 1'b0;
        ram_r_c    = 1'b0;
        ram_en_c   = 1'b0;
        case (op_c)
            OP_WR: begin
                ram_en_c   = 1'b1;
                ram_w_c    = 1'b1;
                ram_add_c  = wptr_q;
                ram_d_in_c = bus.push_data;
            end
            OP_RD: begin
                ram_en_c  = 1'b1;
                ram_r_c   = 1'b1;
                ram_add_c = rptr_q;
            end
            default: ;
        endcase
    end

    // Pointer/occupancy update; a push while full only raises ovf.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        pop_valid_d = 1'b0;
        ovf_d       = ovf_q | (bus.push & full_c);
        case (op_c)
            OP_WR: begin
                wptr_d  = wptr_q + AW'(1);
                count_d = count_q + CW'(1);
            end
            OP_RD: begin
                rptr_d      = rptr_q + AW'(1);
                count_d     = count_q - CW'(1);
                pop_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            pop_valid_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            pop_valid_q <= pop_valid_d;
        end
    end

    assign bus.push_ready = push_ready_c;
    assign bus.pop_ready  = pop_ready_c;
    assign bus.pop_valid  = pop_valid_q;
    assign bus.pop_data   = bus.ram_d_out;
    assign bus.count      = count_q;
    assign bus.full       = full_c;
    assign bus.empty      = empty_c;
    assign bus.ovf        = ovf_q;
    assign bus.ram_add    = ram_add_c;
    assign bus.ram_d_in   = ram_d_in_c;
    assign bus.ram_w      = ram_w_c;
    assign bus.ram_r      = ram_r_c;
    assign bus.ram_en     = ram_en_c;

endmodule

// File: tb/tb_ram8_fifo_ctrl.sv
// tb_ram8_fifo_ctrl: ram8_fifo_ctrl integrated with a ram8 behavioural model.
module tb_ram8_fifo_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram8_fifo_ctrl_if #(.DW(16), .AW(3)) bus ();

    ram8_fifo_ctrl #(.DW(16), .AW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ram8: write at en&w, read register updates at en&r&~w and holds.
    logic [15:0] mem [8];
    initial bus.ram_d_out = 16'h0;
    always @(posedge clk) begin
        if (bus.ram_en && bus.ram_w) mem[bus.ram_add] <= bus.ram_d_in;
        else if (bus.ram_en && bus.ram_r && !bus.ram_w) bus.ram_d_out <= mem[bus.ram_add];
    end

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] mq[$];
    logic [15:0] exp_q[$];
    int m_count, m_wptr, m_rptr;
    bit m_prio, m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete(); exp_q.delete();
        m_count = 0; m_wptr = 0; m_rptr = 0; m_prio = 1'b1; m_ovf = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.push = 1'b0; bus.pop = 1'b0; bus.push_data = '0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        model_reset();
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_pop_valid", bus.pop_valid, 0);
        chk("rst_ram_ctl", {bus.ram_en, bus.ram_w, bus.ram_r}, 0);
        chk("rst_ram_add", bus.ram_add, 0);
        chk("rst_ram_d_in", bus.ram_d_in, 0);
    endtask

    // One clock: drive, check grant-side outputs, step the model, check results.
    task automatic cyc(input bit p, input logic [15:0] d, input bit q,
                       output bit wr_g, output bit rd_g);
        bit wr_e, rd_e;
        bus.push = p; bus.push_data = d; bus.pop = q;
        #1;
        wr_e = p && (m_count < 8);
        rd_e = q && (m_count > 0);
        if (wr_e && rd_e) begin wr_g = m_prio; rd_g = !m_prio; end
        else begin wr_g = wr_e; rd_g = rd_e; end
        chk("push_ready", bus.push_ready, (m_count < 8) && !(wr_e && rd_e && !m_prio));
        chk("pop_ready", bus.pop_ready, (m_count > 0) && !(wr_e && rd_e && m_prio));
        chk("ram_w", bus.ram_w, wr_g);
        chk("ram_r", bus.ram_r, rd_g);
        chk("ram_en", bus.ram_en, wr_g | rd_g);
        chk("ram_w_and_r", bus.ram_w & bus.ram_r, 0);
        if (wr_g) begin
            chk("ram_add_wr", bus.ram_add, m_wptr);
            chk("ram_d_in", bus.ram_d_in, d);
        end else if (rd_g) begin
            chk("ram_add_rd", bus.ram_add, m_rptr);
        end else begin
            chk("ram_add_idle", bus.ram_add, 0);
        end
        @(posedge clk); #1;
        if (p && m_count == 8) m_ovf = 1'b1;
        if (wr_e && rd_e) m_prio = !m_prio;
        if (wr_g) begin mq.push_back(d); m_wptr = (m_wptr + 1) % 8; m_count++; end
        if (rd_g) begin exp_q.push_back(mq.pop_front()); m_rptr = (m_rptr + 1) % 8; m_count--; end
        chk("count", bus.count, m_count);
        chk("full", bus.full, m_count == 8);
        chk("empty", bus.empty, m_count == 0);
        chk("ovf", bus.ovf, m_ovf);
        chk("pop_valid", bus.pop_valid, rd_g);
        if (bus.pop_valid) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL pop_unexpected: got pop_valid=1 with data %0h, required no output", bus.pop_data);
            end else begin
                chk("pop_data", bus.pop_data, exp_q.pop_front());
            end
        end
    endtask

    typedef struct {
        bit          push;
        logic [15:0] data;
        bit          pop;
        int          cnt;
        bit          full;
        bit          empty;
        bit          ovf;
        bit          valid;
    } vec_t;

    vec_t vt[18];
    logic [15:0] snap [8];
    int addr_log[8];
    int exp_addr[8];
    bit wg, rg;

    initial begin
        // Fill 1..8, overflow push 9, drain 8, pop on empty.
        for (int i = 0; i < 8; i++)
            vt[i] = '{1'b1, 16'(i + 1), 1'b0, i + 1, i == 7, 1'b0, 1'b0, 1'b0};
        vt[8] = '{1'b1, 16'd9, 1'b0, 8, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++)
            vt[9 + i] = '{1'b0, 16'h0, 1'b1, 7 - i, 1'b0, i == 7, 1'b1, 1'b1};
        vt[17] = '{1'b0, 16'h0, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0};

        bus.push = 1'b0; bus.pop = 1'b0; bus.push_data = '0;
        do_reset();

        for (int i = 0; i < 18; i++) begin
            if (i == 8) snap = mem;
            cyc(vt[i].push, vt[i].data, vt[i].pop, wg, rg);
            chk($sformatf("vec%0d_count", i), bus.count, vt[i].cnt);
            chk($sformatf("vec%0d_full", i), bus.full, vt[i].full);
            chk($sformatf("vec%0d_empty", i), bus.empty, vt[i].empty);
            chk($sformatf("vec%0d_ovf", i), bus.ovf, vt[i].ovf);
            chk($sformatf("vec%0d_valid", i), bus.pop_valid, vt[i].valid);
            if (i >= 9 && i <= 16) chk($sformatf("vec%0d_data", i), bus.pop_data, i - 8);
            if (i == 8)
                for (int k = 0; k < 8; k++) begin
                    chk($sformatf("ovf_mem%0d", k), mem[k], snap[k]);
                    chk($sformatf("fill_mem%0d", k), mem[k], k + 1);
                end
        end

        // Wrap-around: 5 in, 5 out, then 10..17 must land at 5,6,7,0..4.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 16'(16'h100 + i), 1'b0, wg, rg);
        for (int i = 0; i < 5; i++) cyc(1'b0, 16'h0, 1'b1, wg, rg);
        for (int i = 0; i < 8; i++) begin
            bus.push = 1'b1; bus.push_data = 16'(10 + i); bus.pop = 1'b0;
            #1; addr_log[i] = int'(bus.ram_add);
            exp_addr[i] = (5 + i) % 8;
            #1; cyc(1'b1, 16'(10 + i), 1'b0, wg, rg);
        end
        for (int i = 0; i < 8; i++) chk($sformatf("wrap_add%0d", i), addr_log[i], exp_addr[i]);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 16'h0, 1'b1, wg, rg);
            chk($sformatf("wrap_pop%0d", i), bus.pop_data, 10 + i);
        end

        // Contention at count=4: W,R,W,R,W,R.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 16'(16'h200 + i), 1'b0, wg, rg);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 16'(16'h300 + i), 1'b1, wg, rg);
            chk($sformatf("alt%0d_wr", i), wg, (i % 2) == 0);
            chk($sformatf("alt%0d_rd", i), rg, (i % 2) == 1);
        end
        chk("alt_count_end", bus.count, 4);
        for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0, 1'b1, wg, rg);

        // Pop on empty, then push+pop on empty.
        do_reset();
        cyc(1'b0, 16'h0, 1'b1, wg, rg);
        chk("empty_pop_valid", bus.pop_valid, 0);
        chk("empty_pop_count", bus.count, 0);
        cyc(1'b1, 16'hBEEF, 1'b1, wg, rg);
        chk("empty_pp_count", bus.count, 1);
        chk("empty_pp_valid", bus.pop_valid, 0);
        cyc(1'b0, 16'h0, 1'b1, wg, rg);
        chk("empty_pp_data", bus.pop_data, 16'hBEEF);

        // Reset at count=6 with a pop granted in the same cycle.
        do_reset();
        for (int i = 0; i < 9; i++) cyc(1'b1, 16'(16'h400 + i), 1'b0, wg, rg);
        cyc(1'b0, 16'h0, 1'b1, wg, rg);
        cyc(1'b0, 16'h0, 1'b1, wg, rg);
        chk("mid_pre_count", bus.count, 6);
        chk("mid_pre_ovf", bus.ovf, 1);
        bus.pop = 1'b1; bus.push = 1'b0; rst = 1'b1;
        #1; chk("mid_pop_granted", bus.ram_r, 1);
        @(posedge clk); #1;
        rst = 1'b0; bus.pop = 1'b0;
        model_reset();
        chk("mid_count", bus.count, 0);
        chk("mid_pop_valid", bus.pop_valid, 0);
        chk("mid_ovf", bus.ovf, 0);
        chk("mid_empty", bus.empty, 1);
        cyc(1'b1, 16'hAAAA, 1'b0, wg, rg);
        cyc(1'b0, 16'h0, 1'b1, wg, rg);
        chk("mid_after_data", bus.pop_data, 16'hAAAA);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
